bus_pad_ctrl: RTL and testbench

BUS_PAD_CTRL -- requirements
Module: bus_pad_ctrl

---
 rtl/bus_pad_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bus_pad_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_pad_ctrl.sv
// Pad-side bus controller: conditions active-low control pads and steers the shared data bus.
// Define BUS_PAD_CTRL_FILTER_EN to build the per-channel glitch filter; without it CIN_LVL follows the synchronizer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RX   | bus released, DI_I tracks DI_PAD, waiting for WR_REQ
// ST_TX   | core drives the bus, DO_OE high, DO_PAD follows DO_O
// ST_TURN | dead cycles after TX; DO_OE low, WR_REQ ignored
module bus_pad_ctrl #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 16,
   parameter int NIN         = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int TURN_CYC    = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NIN-1:0]    CIN_PAD,
   output logic [NIN-1:0]    CIN_LVL,
   output logic [NIN-1:0]    CIN_FALL,
   input  logic [DATA_W-1:0] DI_PAD,
   output logic [DATA_W-1:0] DI_I,
   input  logic [DATA_W-1:0] DO_O,
   input  logic              WR_REQ,
   output logic [DATA_W-1:0] DO_PAD,
   output logic              DO_OE,
   input  logic [ADDR_W-1:0] ADDR_O,
   output logic [ADDR_W-1:0] ADDR_PAD,
   output logic              BUS_BUSY
);

   typedef enum logic [1:0] {
      ST_RX   = 2'd0,
      ST_TX   = 2'd1,
      ST_TURN = 2'd2
   } state_e;

   // Synchronizer, stage-major; flops idle at 1 so released pads read as deasserted.
   logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
   logic [NIN-1:0]                  sync_lvl;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], CIN_PAD};
      end
   end

   assign sync_lvl = ~sync_q[SYNC_STAGES-1];

`ifdef BUS_PAD_CTRL_FILTER_EN
   localparam int CNT_W = 4;

   logic [NIN-1:0][CNT_W-1:0] cnt_q;
   logic [NIN-1:0][CNT_W-1:0] cnt_d;
   logic [NIN-1:0]            lvl_q;
   logic [NIN-1:0]            lvl_d;
   logic [NIN-1:0]            fall_q;
   logic [NIN-1:0]            fall_d;

   // A channel flips only after FILT_LEN consecutive disagreeing cycles.
   always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      fall_d = '0;
      for (int i = 0; i < NIN; i++) begin
         if (sync_lvl[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
            cnt_d[i]  = '0;
            lvl_d[i]  = sync_lvl[i];
            fall_d[i] = sync_lvl[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt_q  <= '0;
         lvl_q  <= '0;
         fall_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         fall_q <= fall_d;
      end
   end

   assign CIN_LVL  = lvl_q;
   assign CIN_FALL = fall_q;
`else
   logic [NIN-1:0] lvl_prev_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         lvl_prev_q <= '0;
      end else begin
         lvl_prev_q <= sync_lvl;
      end
   end

   assign CIN_LVL  = sync_lvl;
   assign CIN_FALL = sync_lvl & ~lvl_prev_q;
`endif

   state_e              state_q;
   state_e              state_d;
   logic [2:0]          turn_q;
   logic [2:0]          turn_d;
   logic                oe_q;
   logic                oe_d;
   logic [DATA_W-1:0]   do_pad_q;
   logic [DATA_W-1:0]   do_pad_d;
   logic [DATA_W-1:0]   di_q;
   logic [DATA_W-1:0]   di_d;
   logic [ADDR_W-1:0]   addr_q;

   // turn_q is a down-counter loaded on TX exit; terminal count 0 releases to RX.
   always_comb begin
      state_d = state_q;
      turn_d  = turn_q;
      case (state_q)
         ST_RX: begin
            if (WR_REQ) begin
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            if (!WR_REQ) begin
               state_d = ST_TURN;
               turn_d  = 3'(TURN_CYC - 1);
            end
         end
         ST_TURN: begin
            if (turn_q == 3'd0) begin
               state_d = ST_RX;
            end else begin
               turn_d = turn_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_RX;
         end
      endcase
   end

   // Enable and pad data load from the next state so DO_PAD is valid whenever DO_OE is.
   always_comb begin
      oe_d     = (state_d == ST_TX);
      do_pad_d = do_pad_q;
      di_d     = di_q;
      if (state_d == ST_TX) begin
         do_pad_d = DO_O;
      end
      if (state_q == ST_RX) begin
         di_d = DI_PAD;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_RX;
         turn_q   <= '0;
         oe_q     <= 1'b0;
         do_pad_q <= '0;
         di_q     <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         turn_q   <= turn_d;
         oe_q     <= oe_d;
         do_pad_q <= do_pad_d;
         di_q     <= di_d;
         addr_q   <= ADDR_O;
      end
   end

   assign DO_OE    = oe_q;
   assign DO_PAD   = do_pad_q;
   assign DI_I     = di_q;
   assign ADDR_PAD = addr_q;
   assign BUS_BUSY = (state_q != ST_RX);

endmodule

// File: tb/tb_bus_pad_ctrl.sv
// Self-checking bench for bus_pad_ctrl: table-driven bus and control-pad vectors with a queue scoreboard.
module tb_bus_pad_ctrl;
   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int NIN = 4;
   localparam int SS  = 2;
`ifdef BUS_PAD_CTRL_FILTER_EN
   localparam int FL  = 3;
`else
   localparam int FL  = 0;
`endif
   localparam int LAT = SS + FL;
   localparam int NDV = 15;
   localparam int NCV = 5;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [NIN-1:0] CIN_PAD;
   logic [NIN-1:0] CIN_LVL;
   logic [NIN-1:0] CIN_FALL;
   logic [DW-1:0]  DI_PAD;
   logic [DW-1:0]  DI_I;
   logic [DW-1:0]  DO_O;
   logic           WR_REQ;
   logic [DW-1:0]  DO_PAD;
   logic           DO_OE;
   logic [AW-1:0]  ADDR_O;
   logic [AW-1:0]  ADDR_PAD;
   logic           BUS_BUSY;

   always #5 CLK = ~CLK;

   bus_pad_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .NIN(NIN), .SYNC_STAGES(SS), .FILT_LEN(3), .TURN_CYC(1)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .CIN_PAD(CIN_PAD), .CIN_LVL(CIN_LVL), .CIN_FALL(CIN_FALL),
      .DI_PAD(DI_PAD), .DI_I(DI_I), .DO_O(DO_O), .WR_REQ(WR_REQ),
      .DO_PAD(DO_PAD), .DO_OE(DO_OE), .ADDR_O(ADDR_O), .ADDR_PAD(ADDR_PAD),
      .BUS_BUSY(BUS_BUSY)
   );

   typedef struct packed {
      logic          oe;
      logic [DW-1:0] dpad;
      logic          busy;
      logic [DW-1:0] di;
      logic [AW-1:0] apad;
   } dexp_t;

   typedef struct {
      logic          wr;
      logic [DW-1:0] dout;
      logic [DW-1:0] din;
      logic [AW-1:0] addr;
      dexp_t         e;
   } dvec_t;

   typedef struct packed {
      logic [NIN-1:0] lvl;
      logic [NIN-1:0] fall;
   } cexp_t;

   typedef struct {
      int          ch;
      logic [15:0] pat;
      int          n;
      logic [31:0] lvl;
      logic [31:0] fall;
   } cvec_t;

   dvec_t dv [NDV];
   cvec_t cv [NCV];
   dexp_t dq [$];
   cexp_t cq [$];
   dexp_t de;
   dexp_t da;
   cexp_t ce;
   cexp_t cgot;
   logic [NIN-1:0] pad_v;
   logic [NIN-1:0] any_fall;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic dvec_t mk(input logic wr, input logic [DW-1:0] dout, input logic [DW-1:0] din,
                                input logic [AW-1:0] addr, input logic oe, input logic [DW-1:0] dpad,
                                input logic busy, input logic [DW-1:0] di, input logic [AW-1:0] apad);
      dvec_t v;
      v.wr   = wr;
      v.dout = dout;
      v.din  = din;
      v.addr = addr;
      v.e    = {oe, dpad, busy, di, apad};
      return v;
   endfunction

   function automatic cvec_t mkc(input int ch, input logic [15:0] pat, input int n,
                                 input logic [31:0] lvl, input logic [31:0] fall);
      cvec_t v;
      v.ch   = ch;
      v.pat  = pat;
      v.n    = n;
      v.lvl  = lvl;
      v.fall = fall;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   initial begin
      // inputs: wr, DO_O, DI_PAD, ADDR_O | expected after the edge: oe, DO_PAD, busy, DI_I, ADDR_PAD
      dv[0]  = mk(1'b0, 8'h00, 8'h3C, 16'h0001, 1'b0, 8'h00, 1'b0, 8'h3C, 16'h0001);
      dv[1]  = mk(1'b1, 8'hA5, 8'h3C, 16'h0002, 1'b1, 8'hA5, 1'b1, 8'h3C, 16'h0002);
      dv[2]  = mk(1'b1, 8'hA5, 8'h77, 16'h0003, 1'b1, 8'hA5, 1'b1, 8'h3C, 16'h0003);
      dv[3]  = mk(1'b1, 8'hA5, 8'h78, 16'h0004, 1'b1, 8'hA5, 1'b1, 8'h3C, 16'h0004);
      dv[4]  = mk(1'b0, 8'h11, 8'h79, 16'h0005, 1'b0, 8'hA5, 1'b1, 8'h3C, 16'h0005);
      dv[5]  = mk(1'b0, 8'h12, 8'h7A, 16'h0006, 1'b0, 8'hA5, 1'b0, 8'h3C, 16'h0006);
      dv[6]  = mk(1'b0, 8'h13, 8'h7B, 16'h0007, 1'b0, 8'hA5, 1'b0, 8'h7B, 16'h0007);
      dv[7]  = mk(1'b1, 8'h5A, 8'h3C, 16'h0008, 1'b1, 8'h5A, 1'b1, 8'h3C, 16'h0008);
      dv[8]  = mk(1'b0, 8'h66, 8'h44, 16'h0009, 1'b0, 8'h5A, 1'b1, 8'h3C, 16'h0009);
      dv[9]  = mk(1'b1, 8'h67, 8'h3C, 16'h000A, 1'b0, 8'h5A, 1'b0, 8'h3C, 16'h000A);
      dv[10] = mk(1'b1, 8'h68, 8'h3C, 16'h000B, 1'b1, 8'h68, 1'b1, 8'h3C, 16'h000B);
      dv[11] = mk(1'b1, 8'h69, 8'h99, 16'h000C, 1'b1, 8'h69, 1'b1, 8'h3C, 16'h000C);
      dv[12] = mk(1'b0, 8'h70, 8'h98, 16'h000D, 1'b0, 8'h69, 1'b1, 8'h3C, 16'h000D);
      dv[13] = mk(1'b0, 8'h00, 8'h55, 16'hFFFF, 1'b0, 8'h69, 1'b0, 8'h3C, 16'hFFFF);
      dv[14] = mk(1'b0, 8'h00, 8'h56, 16'h0000, 1'b0, 8'h69, 1'b0, 8'h56, 16'h0000);

      // channel, pad-low pattern (bit k-1 = low at edge k), cycles, expected lvl/fall masks after edge k
`ifdef BUS_PAD_CTRL_FILTER_EN
      cv[0] = mkc(1, 16'hFFFF, 8,  32'h0F0, 32'h010);
      cv[1] = mkc(0, 16'h0003, 12, 32'h000, 32'h000);
      cv[2] = mkc(0, 16'h0007, 12, 32'h070, 32'h010);
      cv[3] = mkc(2, 16'h0001, 8,  32'h000, 32'h000);
      cv[4] = mkc(3, 16'h001B, 14, 32'h000, 32'h000);
`else
      cv[0] = mkc(1, 16'hFFFF, 8,  32'h0FE, 32'h002);
      cv[1] = mkc(0, 16'h0003, 12, 32'h006, 32'h002);
      cv[2] = mkc(0, 16'h0007, 12, 32'h00E, 32'h002);
      cv[3] = mkc(2, 16'h0001, 8,  32'h002, 32'h002);
      cv[4] = mkc(3, 16'h001B, 14, 32'h036, 32'h012);
`endif

      // Reset with every input trying to disturb the outputs.
      RESET   = 1'b0;
      CIN_PAD = '0;
      WR_REQ  = 1'b1;
      DO_O    = 8'hFF;
      DI_PAD  = 8'hAA;
      ADDR_O  = 16'hBEEF;
      repeat (3) tick();
      chk("rst_oe",    DO_OE,    1'b0);
      chk("rst_dpad",  DO_PAD,   8'h00);
      chk("rst_di",    DI_I,     8'h00);
      chk("rst_apad",  ADDR_PAD, 16'h0000);
      chk("rst_busy",  BUS_BUSY, 1'b0);
      chk("rst_lvl",   CIN_LVL,  4'h0);
      chk("rst_fall",  CIN_FALL, 4'h0);

      CIN_PAD = '1;
      WR_REQ  = 1'b0;
      DO_O    = 8'h00;
      DI_PAD  = 8'h00;
      ADDR_O  = 16'h0000;
      RESET   = 1'b1;
      any_fall = '0;
      repeat (LAT + 3) begin
         tick();
         any_fall |= CIN_FALL;
      end
      chk("post_rst_fall", any_fall, 4'h0);
      chk("post_rst_di",   DI_I,     8'h00);

      // Data direction FSM and registered pads.
      for (int i = 0; i < NDV; i++) begin
         WR_REQ = dv[i].wr;
         DO_O   = dv[i].dout;
         DI_PAD = dv[i].din;
         ADDR_O = dv[i].addr;
         dq.push_back(dv[i].e);
         tick();
         de = dq.pop_front();
         da = {DO_OE, DO_PAD, BUS_BUSY, DI_I, ADDR_PAD};
         chk($sformatf("bus_vec%0d", i), da, de);
      end

      // Control pad conditioning.
      for (int c = 0; c < NCV; c++) begin
         for (int k = 1; k <= cv[c].n; k++) begin
            pad_v = '1;
            if (cv[c].pat[k-1]) pad_v[cv[c].ch] = 1'b0;
            CIN_PAD = pad_v;
            ce.lvl  = cv[c].lvl[k-1]  ? NIN'(1 << cv[c].ch) : '0;
            ce.fall = cv[c].fall[k-1] ? NIN'(1 << cv[c].ch) : '0;
            cq.push_back(ce);
            tick();
            cgot = cq.pop_front();
            chk($sformatf("cin%0d_k%0d", c, k), {CIN_LVL, CIN_FALL}, cgot);
         end
         CIN_PAD  = '1;
         any_fall = '0;
         repeat (12) begin
            tick();
            any_fall |= CIN_FALL;
         end
         chk($sformatf("cin%0d_release_fall", c), any_fall, 4'h0);
         chk($sformatf("cin%0d_release_lvl", c),  CIN_LVL,  4'h0);
      end

      // Reset landing in the middle of a TX burst.
      CIN_PAD = 4'b1101;
      WR_REQ  = 1'b1;
      DO_O    = 8'hA5;
      DI_PAD  = 8'h5A;
      ADDR_O  = 16'h1234;
      repeat (LAT + 1) tick();
      chk("midtx_pre_oe",   DO_OE,    1'b1);
      chk("midtx_pre_lvl",  CIN_LVL,  4'b0010);
      chk("midtx_pre_apad", ADDR_PAD, 16'h1234);
      #2;
      RESET = 1'b0;
      #1;
      chk("midtx_oe",   DO_OE,    1'b0);
      chk("midtx_dpad", DO_PAD,   8'h00);
      chk("midtx_apad", ADDR_PAD, 16'h0000);
      chk("midtx_lvl",  CIN_LVL,  4'h0);
      chk("midtx_busy", BUS_BUSY, 1'b0);
      chk("midtx_di",   DI_I,     8'h00);
      tick();
      CIN_PAD = '1;
      WR_REQ  = 1'b0;
      tick();
      RESET = 1'b1;
      any_fall = '0;
      tick();
      chk("rel_busy", BUS_BUSY, 1'b0);
      chk("rel_oe",   DO_OE,    1'b0);
      any_fall |= CIN_FALL;
      repeat (LAT + 2) begin
         tick();
         any_fall |= CIN_FALL;
      end
      chk("rel_fall", any_fall, 4'h0);
      WR_REQ = 1'b1;
      tick();
      chk("rel_tx_oe",   DO_OE,  1'b1);
      chk("rel_tx_dpad", DO_PAD, 8'hA5);
      WR_REQ = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
